// File: rtl/halt_mon_pkg.sv
// Shared types and constants for the halt/drain monitor: FSM state encoding and halt opcodes.
package halt_mon_pkg;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    DRAIN   = 2'd1,
    DONE    = 2'd2,
    TIMEOUT = 2'd3
  } state_t;

  localparam logic [31:0] HALT_EBREAK = 32'h0010_0073;
  localparam logic [31:0] HALT_ECALL  = 32'h0000_0073;

endpackage

// File: rtl/halt_match.sv
// Combinational halt-opcode decoder for the fetch stage.
// Define HALT_ECALL_EN to treat ECALL as a halt in addition to EBREAK.
import halt_mon_pkg::*;

module halt_match (
  input  logic        fetch_valid,
  input  logic [31:0] instr_f,
  output logic        hit
);

  always_comb begin
`ifdef HALT_ECALL_EN
    hit = fetch_valid && ((instr_f == HALT_EBREAK) || (instr_f == HALT_ECALL));
`else
    hit = fetch_valid && (instr_f == HALT_EBREAK);
`endif
  end

endmodule

// File: rtl/halt_drain_monitor.sv
// Halt detection and pipeline-drain controller with a saturating cycle counter and optional watchdog.
// Halt encodings are widened by HALT_ECALL_EN (see halt_match).
import halt_mon_pkg::*;

module halt_drain_monitor #(
  parameter int XLEN           = 32,
  parameter int DRAIN_CYCLES   = 5,
  parameter int CNT_W          = 32,
  parameter int TIMEOUT_CYCLES = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             fetch_valid,
  input  logic [31:0]      instr_f,
  input  logic [XLEN-1:0]  pc_f,
  output logic             halt_seen,
  output logic             drain_active,
  output logic             done,
  output logic             timeout,
  output logic [XLEN-1:0]  halt_pc,
  output logic [CNT_W-1:0] cycle_count,
  output logic [1:0]       state
);

  localparam int DCNT_W = (DRAIN_CYCLES > 0) ? $clog2(DRAIN_CYCLES + 1) : 1;
  localparam logic [DCNT_W-1:0] DRAIN_LAST  = DCNT_W'(DRAIN_CYCLES - 1);
  localparam logic [CNT_W-1:0]  TIMEOUT_VAL = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0]  CNT_MAX     = '1;
  localparam bit                WDOG_EN     = (TIMEOUT_CYCLES != 0);

  state_t            state_q;
  logic [DCNT_W-1:0] drain_cnt;
  logic              halt_hit;
  logic              wdog_fire;
  logic              cnt_en;

  halt_match u_match (
    .fetch_valid (fetch_valid),
    .instr_f     (instr_f),
    .hit         (halt_hit)
  );

  // The count freezes on the edge that enters TIMEOUT, so it reads exactly TIMEOUT_CYCLES there.
  always_comb begin
    wdog_fire = WDOG_EN && (cycle_count == TIMEOUT_VAL);
    cnt_en    = (state_q == DRAIN) || ((state_q == RUN) && (halt_hit || !wdog_fire));
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= RUN;
      drain_cnt    <= '0;
      halt_pc      <= '0;
      cycle_count  <= '0;
      halt_seen    <= 1'b0;
      drain_active <= 1'b0;
      done         <= 1'b0;
      timeout      <= 1'b0;
    end else begin
      if (cnt_en && (cycle_count != CNT_MAX))
        cycle_count <= cycle_count + CNT_W'(1);

      case (state_q)
        RUN: begin
          if (halt_hit) begin
            halt_pc   <= pc_f;
            drain_cnt <= '0;
            halt_seen <= 1'b1;
            if (DRAIN_CYCLES == 0) begin
              state_q <= DONE;
              done    <= 1'b1;
            end else begin
              state_q      <= DRAIN;
              drain_active <= 1'b1;
            end
          end else if (wdog_fire) begin
            state_q <= TIMEOUT;
            timeout <= 1'b1;
            done    <= 1'b1;
          end
        end
        DRAIN: begin
          drain_cnt <= drain_cnt + DCNT_W'(1);
          if (drain_cnt == DRAIN_LAST) begin
            state_q      <= DONE;
            drain_active <= 1'b0;
            done         <= 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_halt_drain_monitor.sv
// Scoreboard bench: four monitor configurations share one stimulus stream; expectations are
// queued with the edge number at which they must hold and checked on the following falling edge.
module tb_halt_drain_monitor;

  localparam logic [31:0] EBREAK = 32'h0010_0073;
  localparam logic [31:0] ECALL  = 32'h0000_0073;
  localparam logic [31:0] NOP    = 32'h0000_0013;
  localparam int D5 = 0;
  localparam int D0 = 1;
  localparam int DT = 2;
  localparam int DS = 3;

  typedef struct {
    int          cyc;
    int          idx;
    string       name;
    logic [1:0]  st;
    logic        hs;
    logic        da;
    logic        dn;
    logic        to;
    logic [31:0] hpc;
    logic [31:0] cc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_valid;
  logic [31:0] instr_f;
  logic [31:0] pc_f;

  logic [1:0]  st_o [4];
  logic        hs_o [4];
  logic        da_o [4];
  logic        dn_o [4];
  logic        to_o [4];
  logic [31:0] hpc_o [4];
  logic [31:0] cc_o [3];
  logic [3:0]  cc_s;

  exp_t sbq[$];
  int   cyc = 0;
  int   checkCount = 0;
  int   passCount = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  halt_drain_monitor dut_d5 (
    .clk(clk), .rst(rst), .fetch_valid(fetch_valid), .instr_f(instr_f), .pc_f(pc_f),
    .halt_seen(hs_o[D5]), .drain_active(da_o[D5]), .done(dn_o[D5]), .timeout(to_o[D5]),
    .halt_pc(hpc_o[D5]), .cycle_count(cc_o[D5]), .state(st_o[D5])
  );

  halt_drain_monitor #(.DRAIN_CYCLES(0)) dut_d0 (
    .clk(clk), .rst(rst), .fetch_valid(fetch_valid), .instr_f(instr_f), .pc_f(pc_f),
    .halt_seen(hs_o[D0]), .drain_active(da_o[D0]), .done(dn_o[D0]), .timeout(to_o[D0]),
    .halt_pc(hpc_o[D0]), .cycle_count(cc_o[D0]), .state(st_o[D0])
  );

  halt_drain_monitor #(.TIMEOUT_CYCLES(10)) dut_dt (
    .clk(clk), .rst(rst), .fetch_valid(fetch_valid), .instr_f(instr_f), .pc_f(pc_f),
    .halt_seen(hs_o[DT]), .drain_active(da_o[DT]), .done(dn_o[DT]), .timeout(to_o[DT]),
    .halt_pc(hpc_o[DT]), .cycle_count(cc_o[DT]), .state(st_o[DT])
  );

  halt_drain_monitor #(.CNT_W(4)) dut_ds (
    .clk(clk), .rst(rst), .fetch_valid(fetch_valid), .instr_f(instr_f), .pc_f(pc_f),
    .halt_seen(hs_o[DS]), .drain_active(da_o[DS]), .done(dn_o[DS]), .timeout(to_o[DS]),
    .halt_pc(hpc_o[DS]), .cycle_count(cc_s), .state(st_o[DS])
  );

  task automatic pushExp(input int c, input int idx, input string name, input logic [1:0] st,
                         input logic hs, input logic da, input logic dn, input logic to,
                         input logic [31:0] hpc, input logic [31:0] cc);
    exp_t e;
    e.cyc = c; e.idx = idx; e.name = name; e.st = st;
    e.hs = hs; e.da = da; e.dn = dn; e.to = to; e.hpc = hpc; e.cc = cc;
    sbq.push_back(e);
  endtask

  task automatic pushIdle(input int c, input int idx, input string name, input logic [31:0] cc);
    pushExp(c, idx, name, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, cc);
  endtask

  task automatic applyStimulus(input logic r, input logic fv, input logic [31:0] ins,
                               input logic [31:0] pc);
    rst = r;
    fetch_valid = fv;
    instr_f = ins;
    pc_f = pc;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input exp_t e);
    logic [31:0] gotCc;
    gotCc = (e.idx == DS) ? {28'd0, cc_s} : cc_o[e.idx];
    checkCount++;
    if (st_o[e.idx] === e.st && hs_o[e.idx] === e.hs && da_o[e.idx] === e.da &&
        dn_o[e.idx] === e.dn && to_o[e.idx] === e.to && hpc_o[e.idx] === e.hpc &&
        gotCc === e.cc)
      passCount++;
    else
      $display("[TB] FAIL %s @edge %0d: got st=%0d hs=%b da=%b dn=%b to=%b pc=%h cc=%0d, expected st=%0d hs=%b da=%b dn=%b to=%b pc=%h cc=%0d",
               e.name, e.cyc, st_o[e.idx], hs_o[e.idx], da_o[e.idx], dn_o[e.idx], to_o[e.idx],
               hpc_o[e.idx], gotCc, e.st, e.hs, e.da, e.dn, e.to, e.hpc, e.cc);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      while (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
        e = sbq.pop_front();
        if (e.cyc < cyc) begin
          checkCount++;
          $display("[TB] FAIL %s: expectation for edge %0d missed, now at edge %0d", e.name, e.cyc, cyc);
        end else begin
          checkOutput(e);
        end
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("[TB] FAIL global_timeout: simulation still running at %0t", $time);
    $fatal(1, "[TB] bench did not terminate");
  end

  initial begin : stimulus
    exp_t e;

    // Reset, invalid EBREAK ignored, watchdog expiry and counter saturation.
    for (int i = 0; i < 4; i++) pushIdle(3, i, $sformatf("reset_%0d", i), 32'd0);
    for (int i = 0; i < 4; i++) pushIdle(5, i, $sformatf("invalid_ebreak_%0d", i), 32'd2);
    pushIdle(13, DT, "wdog_before", 32'd10);
    pushIdle(14, D5, "no_wdog_d5", 32'd11);
    pushExp(14, DT, "wdog_fire", 2'd3, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0, 32'd10);
    pushExp(15, DT, "wdog_frozen", 2'd3, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0, 32'd10);
    pushIdle(17, DS, "sat_before", 32'd14);
    pushIdle(18, DS, "sat_reach", 32'd15);
    pushIdle(20, D5, "count_d5", 32'd17);
    pushIdle(20, DS, "sat_hold", 32'd15);
    repeat (3) applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
    repeat (2) applyStimulus(1'b1, 1'b0, EBREAK, 32'h40);
    for (int i = 0; i < 15; i++) applyStimulus(1'b1, 1'b1, NOP, 32'h100 + 32'(4 * i));

    // Halt on the watchdog edge, drain, and ignored second halt.
    pushIdle(21, D5, "reset_from_run", 32'd0);
    pushIdle(21, DT, "reset_from_timeout", 32'd0);
    pushIdle(31, DT, "wdog_armed", 32'd10);
    pushExp(32, D5, "halt_capture", 2'd1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h40, 32'd11);
    pushExp(32, D0, "halt_no_drain", 2'd2, 1'b1, 1'b0, 1'b1, 1'b0, 32'h40, 32'd11);
    pushExp(32, DT, "halt_beats_wdog", 2'd1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h40, 32'd11);
    pushExp(33, D5, "second_halt_ignored", 2'd1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h40, 32'd12);
    pushExp(33, D0, "done_terminal", 2'd2, 1'b1, 1'b0, 1'b1, 1'b0, 32'h40, 32'd11);
    pushExp(36, D5, "drain_last", 2'd1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h40, 32'd15);
    pushExp(37, D5, "drain_done", 2'd2, 1'b1, 1'b0, 1'b1, 1'b0, 32'h40, 32'd16);
    pushExp(37, DT, "drain_no_wdog", 2'd2, 1'b1, 1'b0, 1'b1, 1'b0, 32'h40, 32'd16);
    pushExp(39, D5, "done_sticky", 2'd2, 1'b1, 1'b0, 1'b1, 1'b0, 32'h40, 32'd16);
    applyStimulus(1'b0, 1'b0, NOP, 32'h0);
    for (int i = 0; i < 10; i++) applyStimulus(1'b1, 1'b1, NOP, 32'h10 + 32'(4 * i));
    applyStimulus(1'b1, 1'b1, EBREAK, 32'h40);
    applyStimulus(1'b1, 1'b1, EBREAK, 32'h44);
    repeat (6) applyStimulus(1'b1, 1'b1, NOP, 32'h48);

    // Reset in the middle of a drain, then a fresh full drain.
    pushIdle(40, D5, "reset_from_done", 32'd0);
    pushExp(41, D5, "halt2_capture", 2'd1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h40, 32'd1);
    pushExp(43, D5, "halt2_draining", 2'd1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h40, 32'd3);
    pushIdle(44, D5, "reset_mid_drain", 32'd0);
    pushIdle(44, D0, "reset_d0_done", 32'd0);
    pushExp(45, D5, "halt3_capture", 2'd1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h48, 32'd1);
    pushExp(49, D5, "halt3_full_drain", 2'd1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h48, 32'd5);
    pushExp(50, D5, "halt3_done", 2'd2, 1'b1, 1'b0, 1'b1, 1'b0, 32'h48, 32'd6);
    applyStimulus(1'b0, 1'b0, NOP, 32'h0);
    applyStimulus(1'b1, 1'b1, EBREAK, 32'h40);
    repeat (2) applyStimulus(1'b1, 1'b1, NOP, 32'h44);
    applyStimulus(1'b0, 1'b1, NOP, 32'h0);
    applyStimulus(1'b1, 1'b1, EBREAK, 32'h48);
    repeat (5) applyStimulus(1'b1, 1'b1, NOP, 32'h4c);

    // ECALL is a halt only when the optional encoding is enabled.
`ifdef HALT_ECALL_EN
    pushExp(52, D5, "ecall_capture", 2'd1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h80, 32'd1);
    pushExp(52, D0, "ecall_no_drain", 2'd2, 1'b1, 1'b0, 1'b1, 1'b0, 32'h80, 32'd1);
    pushExp(56, D5, "ecall_draining", 2'd1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h80, 32'd5);
    pushExp(57, D5, "ecall_done", 2'd2, 1'b1, 1'b0, 1'b1, 1'b0, 32'h80, 32'd6);
`else
    pushIdle(52, D5, "ecall_ignored", 32'd1);
    pushIdle(52, D0, "ecall_ignored_d0", 32'd1);
    pushIdle(56, D5, "ecall_still_run", 32'd5);
    pushIdle(57, D5, "ecall_run_final", 32'd6);
`endif
    applyStimulus(1'b0, 1'b0, NOP, 32'h0);
    applyStimulus(1'b1, 1'b1, ECALL, 32'h80);
    repeat (5) applyStimulus(1'b1, 1'b1, NOP, 32'h84);

    for (int i = 0; i < 5 && sbq.size() > 0; i++) @(negedge clk);
    #1;
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      checkCount++;
      $display("[TB] FAIL %s: expectation for edge %0d never checked", e.name, e.cyc);
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
